// File: rtl/fifo_rd_packer.sv
// Purpose : packs RATIO show-ahead FIFO words into one wide word, lane 0 first; i_flush emits a partial word.
// Latency : o_valid rises on the same edge that pops the word completing (or flushing) the output.
// Backpres: output register holds while i_ready=0; the completing pop and flush emission wait for out_free.
//
// Ports:
//   i_rclk, i_rrst          clock, asynchronous active-high reset
//   i_fifo_rdata/_empty     show-ahead FIFO read side; o_fifo_ren pops a word when the FIFO is non-empty
//   i_flush                 one-cycle request to emit the current partial word
//   o_data/o_keep/o_valid   packed word, lane-valid mask, valid; i_ready accepts
// Optional feature: define PACK_TIMEOUT_EN to auto-flush a partial word after TIMEOUT idle cycles.
module fifo_rd_packer #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                        i_rclk,
    input  logic                        i_rrst,
    input  logic [IN_WIDTH-1:0]         i_fifo_rdata,
    input  logic                        i_fifo_empty,
    output logic                        o_fifo_ren,
    input  logic                        i_flush,
    output logic [IN_WIDTH*RATIO-1:0]   o_data,
    output logic [RATIO-1:0]            o_keep,
    output logic                        o_valid,
    input  logic                        i_ready
);
    localparam int CW = $clog2(RATIO);
    localparam int NW = CW + 1;
    localparam int OW = IN_WIDTH * RATIO;
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [OW-1:0]      acc_q, acc_d;
    logic [OW-1:0]      acc_ins;      // accumulator with this cycle's popped word in lane cnt
    logic [NW-1:0]      n_words;      // words held once this cycle's pop is counted
    logic [RATIO-1:0]   keep_part;
    logic [OW-1:0]      data_d;
    logic [RATIO-1:0]   keep_d;
    logic               valid_d;
    logic               out_free;
    logic               pop;
    logic               flush_req;
    logic               emit;

    assign out_free   = !o_valid || i_ready;
    // The word completing an output may only be popped when the output register can take it.
    assign o_fifo_ren = !i_fifo_empty && (state_q != S_FLUSH) &&
                        ((cnt_q != LAST) || out_free) && !i_rrst;
    assign pop        = o_fifo_ren;

`ifdef PACK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt_q;
    logic          to_hit;

    // Fires on the TIMEOUT-th consecutive cycle in S_FILL without a pop.
    assign to_hit    = (state_q == S_FILL) && !pop && (to_cnt_q == TW'(TIMEOUT - 1));
    assign flush_req = i_flush || to_hit;

    always_ff @(posedge i_rclk or posedge i_rrst) begin
        if (i_rrst) begin
            to_cnt_q <= '0;
        end else if ((state_q == S_FILL) && (state_d == S_FILL) && !pop) begin
            to_cnt_q <= to_cnt_q + TW'(1);
        end else begin
            to_cnt_q <= '0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign flush_req      = i_flush;
`endif

    always_comb begin
        acc_ins = acc_q;
        for (int k = 0; k < RATIO; k++) begin
            if (pop && (CW'(k) == cnt_q)) begin
                acc_ins[k*IN_WIDTH +: IN_WIDTH] = i_fifo_rdata;
            end
        end
        n_words = {1'b0, cnt_q} + {{CW{1'b0}}, pop};
        for (int k = 0; k < RATIO; k++) begin
            keep_part[k] = (NW'(k) < n_words);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        data_d  = o_data;
        keep_d  = o_keep;
        valid_d = o_valid && !i_ready;
        emit    = 1'b0;

        if (pop && (cnt_q == LAST)) begin
            // Full word; any flush this cycle is satisfied by it.
            emit    = 1'b1;
            data_d  = acc_ins;
            keep_d  = '1;
            cnt_d   = '0;
            acc_d   = '0;
            state_d = S_IDLE;
        end else if (state_q == S_FLUSH) begin
            if (out_free) begin
                emit    = 1'b1;
                data_d  = acc_q;
                keep_d  = keep_part;
                cnt_d   = '0;
                acc_d   = '0;
                state_d = S_IDLE;
            end
        end else if (flush_req && ((state_q == S_FILL) || pop)) begin
            if (out_free) begin
                emit    = 1'b1;
                data_d  = acc_ins;      // unused lanes are zero: acc is cleared on every emission
                keep_d  = keep_part;
                cnt_d   = '0;
                acc_d   = '0;
                state_d = S_IDLE;
            end else begin
                acc_d   = acc_ins;
                cnt_d   = n_words[CW-1:0];
                state_d = S_FLUSH;
            end
        end else if (pop) begin
            acc_d   = acc_ins;
            cnt_d   = cnt_q + CW'(1);
            state_d = S_FILL;
        end

        if (emit) begin
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_rclk or posedge i_rrst) begin
        if (i_rrst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            o_data  <= '0;
            o_keep  <= '0;
            o_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            o_data  <= data_d;
            o_keep  <= keep_d;
            o_valid <= valid_d;
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Purpose : self-checking bench for fifo_rd_packer with a queue-based FIFO and grouping model.
// Latency : checks output words at acceptance, plus directed timing/stall checks.
// Backpres: drives random i_ready; the scoreboard tolerates any stall pattern.
module tb_fifo_rd_packer;
    localparam int W = 8;
    localparam int R = 4;
    localparam int T = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   i_fifo_rdata = '0;
    logic           i_fifo_empty = 1'b1;
    logic           o_fifo_ren;
    logic           i_flush = 1'b0;
    logic [W*R-1:0] o_data;
    logic [R-1:0]   o_keep;
    logic           o_valid;
    logic           i_ready = 1'b0;

    always #5 clk = ~clk;

    fifo_rd_packer #(.IN_WIDTH(W), .RATIO(R), .TIMEOUT(T)) dut (
        .i_rclk(clk), .i_rrst(rst),
        .i_fifo_rdata(i_fifo_rdata), .i_fifo_empty(i_fifo_empty), .o_fifo_ren(o_fifo_ren),
        .i_flush(i_flush),
        .o_data(o_data), .o_keep(o_keep), .o_valid(o_valid), .i_ready(i_ready)
    );

    int             errors = 0;
    int             checks = 0;
    logic [W-1:0]   fifo_q[$];
    logic [W-1:0]   grp[$];          // words popped into the output word being built
    logic [W*R-1:0] exp_data_q[$];
    logic [R-1:0]   exp_keep_q[$];
    int             partials_out = 0;
    int             idle = 0;
    logic           pop_d;
    logic [W*R-1:0] mon_d;
    logic [R-1:0]   mon_k;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void drive_fifo();
        i_fifo_empty = (fifo_q.size() == 0);
        i_fifo_rdata = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    endfunction

    task automatic push_word(input logic [W-1:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    // Close the current group: words in arrival order from lane 0, unused lanes zero.
    function automatic void close_group();
        logic [W*R-1:0] d;
        logic [R-1:0]   k;
        d = '0;
        k = '0;
        foreach (grp[i]) begin
            d[i*W +: W] = grp[i];
            k[i]        = 1'b1;
        end
        exp_data_q.push_back(d);
        exp_keep_q.push_back(k);
        if (grp.size() < R) partials_out++;
        grp.delete();
        idle = 0;
    endfunction

    // One clock: model samples at the falling edge, FIFO model pops after the rising edge.
    task automatic step();
        @(negedge clk);
        pop_d = 1'b0;
        if (!rst) begin
            if (i_fifo_empty) check("ren_when_empty", 64'(o_fifo_ren), 64'h0);
            else if (grp.size() < R - 1 && partials_out == 0)
                check("ren_when_room", 64'(o_fifo_ren), 64'h1);
            pop_d = o_fifo_ren && !i_fifo_empty;
            if (pop_d) begin
                grp.push_back(fifo_q[0]);
                idle = 0;
            end
            if (grp.size() == R) close_group();
            else if (i_flush && grp.size() > 0) close_group();
`ifdef PACK_TIMEOUT_EN
            else if (!pop_d && grp.size() > 0) begin
                idle++;
                if (idle == T) close_group();
            end
`endif
        end
        @(posedge clk);
        #1;
        if (pop_d) void'(fifo_q.pop_front());
        drive_fifo();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        #1;
        check("rst_valid", 64'(o_valid), 64'h0);
        check("rst_ren", 64'(o_fifo_ren), 64'h0);
        check("rst_data", 64'(o_data), 64'h0);
        check("rst_keep", 64'(o_keep), 64'h0);
        grp.delete();
        exp_data_q.delete();
        exp_keep_q.delete();
        partials_out = 0;
        idle = 0;
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        i_ready = 1'b1;
        while ((fifo_q.size() > 0 || grp.size() > 0 || exp_data_q.size() > 0) && n < 400) begin
            i_flush = (fifo_q.size() == 0 && grp.size() > 0);
            step();
            n++;
        end
        i_flush = 1'b0;
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL %s_drain: %0d fifo words, %0d held, %0d outputs still expected",
                     name, fifo_q.size(), grp.size(), exp_data_q.size());
        end
    endtask

    // Scoreboard monitor: every accepted output must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && o_valid && i_ready) begin
            if (exp_data_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got data 0x%0h keep 0x%0h, none expected", o_data, o_keep);
            end else begin
                mon_d = exp_data_q.pop_front();
                mon_k = exp_keep_q.pop_front();
                check("out_data", 64'(o_data), 64'(mon_d));
                check("out_keep", 64'(o_keep), 64'(mon_k));
                if (mon_k != '1) partials_out--;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_valid;
        do_reset(3);

        // Back-to-back full word.
        i_ready = 1'b1;
        push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
        repeat (3) step();
        check("full_valid_early", 64'(o_valid), 64'h0);
        step();
        check("full_valid", 64'(o_valid), 64'h1);
        check("full_data", 64'(o_data), 64'h44332211);
        check("full_keep", 64'(o_keep), 64'hF);
        drain("full");

        // Backpressure: pops stall at the word that would complete the second output.
        i_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_word(W'(i));
        repeat (8) step();
        check("stall_ren", 64'(o_fifo_ren), 64'h0);
        check("stall_valid", 64'(o_valid), 64'h1);
        check("stall_data", 64'(o_data), 64'h04030201);
        drain("stall");

        // Flush of a two-word partial, then normal packing from lane 0.
        i_ready = 1'b1;
        push_word(8'hAA); push_word(8'hBB);
        repeat (2) step();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        check("flush_valid", 64'(o_valid), 64'h1);
        check("flush_data", 64'(o_data), 64'h0000BBAA);
        check("flush_keep", 64'(o_keep), 64'h3);
        push_word(8'hC1); push_word(8'hC2); push_word(8'hC3); push_word(8'hC4);
        drain("after_flush");

        // Flush while the output register is blocked.
        i_ready = 1'b0;
        push_word(8'h01); push_word(8'h02); push_word(8'h03); push_word(8'h04); push_word(8'hAA);
        repeat (5) step();
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        push_word(8'h77);
        repeat (2) step();
        check("flushwait_ren", 64'(o_fifo_ren), 64'h0);
        check("flushwait_data", 64'(o_data), 64'h04030201);
        i_ready = 1'b1;
        step();
        check("flushwait_valid", 64'(o_valid), 64'h1);
        check("flushwait_pdata", 64'(o_data), 64'h000000AA);
        check("flushwait_pkeep", 64'(o_keep), 64'h1);
        drain("flushwait");

        // Reset mid-fill discards the partial word.
        i_ready = 1'b1;
        push_word(8'h11); push_word(8'h22);
        repeat (2) step();
        push_word(8'h31); push_word(8'h32); push_word(8'h33); push_word(8'h34);
        do_reset(2);
        drain("after_reset");

        // Idle partial word: auto-flush when enabled, otherwise held.
        i_ready = 1'b1;
        push_word(8'h5A);
        step();
`ifdef PACK_TIMEOUT_EN
        repeat (T - 1) step();
        check("timeout_early", 64'(o_valid), 64'h0);
        step();
        check("timeout_valid", 64'(o_valid), 64'h1);
        check("timeout_data", 64'(o_data), 64'h0000005A);
        check("timeout_keep", 64'(o_keep), 64'h1);
`else
        seen_valid = 1'b0;
        repeat (100) begin
            step();
            seen_valid = seen_valid | o_valid;
        end
        check("no_timeout", 64'(seen_valid), 64'h0);
`endif
        drain("timeout");

        // Randomized traffic, backpressure and flushes, with one reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            i_ready = ($urandom_range(0, 9) < 7);
            i_flush = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 9) < 6 && fifo_q.size() < 8) push_word(W'($urandom));
            if (c == 1500) do_reset(2);
            step();
        end
        i_flush = 1'b0;
        drain("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
